// File: rtl/enigma_pkg.sv
// enigma_pkg: shared ASCII bounds, case offset, FSM states and character helpers
package enigma_pkg;
  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;
  localparam logic [7:0] CASE_OFS = 8'h20;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, OUT} state_t;
  function automatic logic [7:0] to_upper(input logic [7:0] c);
    return (c >= LOWER_LO && c <= LOWER_HI) ? c - CASE_OFS : c;
  endfunction
  function automatic logic is_upper(input logic [7:0] c);
    return c >= UPPER_LO && c <= UPPER_HI;
  endfunction
endpackage

// File: rtl/enigma_char_fifo.sv
// enigma_char_fifo: synchronous FIFO with wrap-bit pointers, combinational head read
module enigma_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/enigma_feeder.sv
// enigma_feeder: buffers ASCII letters, feeds them one at a time to a cipher core and forwards results
module enigma_feeder import enigma_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        mode_dec,
  output logic        core_valid,
  output logic [7:0]  core_din,
  output logic        core_en,
  output logic        core_dec,
  input  logic [7:0]  core_dout,
  input  logic        core_done,
  output logic        m_valid,
  output logic [7:0]  m_data,
  input  logic        m_ready,
  output logic [15:0] char_cnt,
  output logic        err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, next;
  logic [7:0] up, head;
  logic [TW-1:0] tcnt;
  logic full, empty, push, pop, timeout;
  assign up         = to_upper(s_data);
  assign s_ready    = !full && !reset;
  assign push       = s_valid && s_ready && is_upper(up);
  assign pop        = state == IDLE && !empty;
  assign timeout    = state == WAIT && !core_done && tcnt == TW'(TIMEOUT - 1);
  assign core_valid = state == LOAD;
  assign core_en    = state == LOAD || state == WAIT;
  assign m_valid    = state == OUT;
  enigma_char_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din(up),
    .pop(pop), .dout(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = empty ? IDLE : LOAD;
      LOAD:    next = WAIT;
      WAIT:    next = core_done ? OUT : (timeout ? IDLE : WAIT);
      OUT:     next = m_ready ? IDLE : OUT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      core_din <= '0;
      core_dec <= 1'b0;
      m_data   <= '0;
      char_cnt <= '0;
      err      <= 1'b0;
      tcnt     <= '0;
    end else begin
      if (pop) begin
        core_din <= head;
        core_dec <= mode_dec;
      end
      if (state == LOAD) tcnt <= '0;
      else if (state == WAIT && !core_done) tcnt <= tcnt + TW'(1);
      if (state == WAIT && core_done) m_data <= core_dout;
      if (timeout) err <= 1'b1;
      if (state == OUT && m_ready) char_cnt <= char_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_enigma_feeder.sv
// tb_enigma_feeder: directed vector table plus timeout, stall, hold and reset sequences
module tb_enigma_feeder;
  logic clk = 1'b0, reset = 1'b1, s_valid = 1'b0, mode_dec = 1'b0, core_done = 1'b0, m_ready = 1'b0;
  logic [7:0] s_data = '0, core_dout = '0;
  logic s_ready, core_valid, core_en, core_dec, m_valid, err;
  logic [7:0] core_din, m_data;
  logic [15:0] char_cnt;
  int total = 0, bad = 0, cyc = 0, loads = 0, xfers = 0, exp_cnt = 0;
  typedef struct {
    logic [7:0] d;
    logic       mode;
    logic       letter;
    logic [7:0] din;
    logic [7:0] ret;
  } vec_t;
  vec_t vt[11];
  enigma_feeder #(.FIFO_DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mode_dec(mode_dec), .core_valid(core_valid), .core_din(core_din), .core_en(core_en),
    .core_dec(core_dec), .core_dout(core_dout), .core_done(core_done), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .char_cnt(char_cnt), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_valid) loads <= loads + 1;
    if (m_valid && m_ready) xfers <= xfers + 1;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"}, {31'd0, core_valid}, 0);
    chk({tag, "_en"}, {31'd0, core_en}, 0);
    chk({tag, "_din"}, {24'd0, core_din}, 0);
    chk({tag, "_dec"}, {31'd0, core_dec}, 0);
    chk({tag, "_mvld"}, {31'd0, m_valid}, 0);
    chk({tag, "_mdata"}, {24'd0, m_data}, 0);
    chk({tag, "_cnt"}, {16'd0, char_cnt}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
  endtask
  task automatic serve(input logic [7:0] din, input logic [7:0] ret);
    logic dec;
    int k;
    k = 0;
    while (!core_valid && k < 100) begin
      tick();
      k++;
    end
    dec = mode_dec;
    chk("load_seen", {31'd0, core_valid}, 1);
    chk("core_din", {24'd0, core_din}, {24'd0, din});
    chk("core_dec", {31'd0, core_dec}, {31'd0, dec});
    chk("en_load", {31'd0, core_en}, 1);
    mode_dec = ~mode_dec;
    tick();
    chk("valid_1cyc", {31'd0, core_valid}, 0);
    chk("en_wait", {31'd0, core_en}, 1);
    chk("dec_hold", {31'd0, core_dec}, {31'd0, dec});
    chk("din_hold", {24'd0, core_din}, {24'd0, din});
    core_dout = ret;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    core_dout = '0;
    chk("m_valid", {31'd0, m_valid}, 1);
    chk("m_data", {24'd0, m_data}, {24'd0, ret});
    chk("en_out", {31'd0, core_en}, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_cnt++;
    chk("m_valid_drop", {31'd0, m_valid}, 0);
    chk("char_cnt", {16'd0, char_cnt}, exp_cnt);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, k, leak, load_cyc;
    logic [7:0] stall_chars[5];
    vt[0]  = '{8'h68, 1'b0, 1'b1, 8'h48, 8'h51};
    vt[1]  = '{8'h33, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[2]  = '{8'h20, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[3]  = '{8'h5A, 1'b1, 1'b1, 8'h5A, 8'h41};
    vt[4]  = '{8'h61, 1'b1, 1'b1, 8'h41, 8'h4B};
    vt[5]  = '{8'h7A, 1'b0, 1'b1, 8'h5A, 8'h58};
    vt[6]  = '{8'h41, 1'b0, 1'b1, 8'h41, 8'h59};
    vt[7]  = '{8'h40, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[8]  = '{8'h5B, 1'b1, 1'b0, 8'h00, 8'h00};
    vt[9]  = '{8'h60, 1'b0, 1'b0, 8'h00, 8'h00};
    vt[10] = '{8'h7B, 1'b1, 1'b0, 8'h00, 8'h00};
    stall_chars = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    tick();
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk_reset_outs("rst");
    reset = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, s_ready}, 1);
    for (int i = 0; i < 11; i++) begin
      mode_dec = vt[i].mode;
      s_data = vt[i].d;
      s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      if (vt[i].letter) begin
        tick();
        chk("min_latency", {31'd0, core_valid}, 1);
        serve(vt[i].din, vt[i].ret);
      end else begin
        n = loads;
        repeat (4) tick();
        chk("drop_no_load", loads, n);
        chk("drop_cnt", {16'd0, char_cnt}, exp_cnt);
      end
    end
    mode_dec = 1'b0;
    s_data = 8'h6D;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    chk("hold_load", {31'd0, core_valid}, 1);
    tick();
    core_dout = 8'h3C;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    for (int j = 0; j < 10; j++) begin
      chk("hold_mvld", {31'd0, m_valid}, 1);
      chk("hold_mdata", {24'd0, m_data}, 32'h3C);
      chk("hold_cnt", {16'd0, char_cnt}, exp_cnt);
      core_dout = 8'hEE;
      core_done = (j == 3);
      tick();
      core_done = 1'b0;
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    exp_cnt++;
    chk("hold_accept_cnt", {16'd0, char_cnt}, exp_cnt);
    chk("hold_accept_vld", {31'd0, m_valid}, 0);
    m_ready = 1'b1;
    load_cyc = -1000;
    for (int j = 0; j < 5; j++) begin
      s_data = stall_chars[j];
      s_valid = 1'b1;
      tick();
      if (core_valid) load_cyc = cyc;
    end
    s_valid = 1'b0;
    chk("stall_full", {31'd0, s_ready}, 0);
    chk("stall_din", {24'd0, core_din}, 32'h41);
    k = 0;
    leak = 0;
    while (!err && k < 200) begin
      if (s_ready) leak++;
      tick();
      k++;
    end
    chk("timeout_err", {31'd0, err}, 1);
    chk("timeout_cycles", cyc - load_cyc, 65);
    chk("stall_no_ready", leak, 0);
    chk("timeout_idle", {31'd0, core_en}, 0);
    chk("timeout_no_out", {31'd0, m_valid}, 0);
    m_ready = 1'b0;
    serve(8'h42, 8'h10);
    serve(8'h43, 8'h11);
    serve(8'h44, 8'h12);
    serve(8'h45, 8'h13);
    chk("err_sticky", {31'd0, err}, 1);
    s_data = 8'h71;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    chk("mid_wait_en", {31'd0, core_en}, 1);
    n = xfers;
    reset = 1'b1;
    tick();
    chk("mid_rst_s_ready", {31'd0, s_ready}, 0);
    chk_reset_outs("mid_rst");
    reset = 1'b0;
    core_dout = 8'h77;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    m_ready = 1'b0;
    chk("late_done_mvld", {31'd0, m_valid}, 0);
    chk("late_done_mdata", {24'd0, m_data}, 0);
    chk("late_done_xfer", xfers, n);
    chk("post_rst_ready", {31'd0, s_ready}, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enigma_feeder.md
ENIGMA_FEEDER -- requirements
Module: enigma_feeder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, input character buffer depth (power of two, >=2).
REQ-002 The block SHALL have parameter TIMEOUT, default 64, maximum cycles to wait for core_done.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  upstream byte valid.
REQ-006 s_data  input  8  upstream ASCII byte.
REQ-007 s_ready  output  1  block accepts s_data this cycle.
REQ-008 mode_dec  input  1  0 = encrypt, 1 = decrypt; forwarded to core.
REQ-009 core_valid  output  1  one-cycle load strobe to cipher core.
REQ-010 core_din  output  8  uppercase letter to core.
REQ-011 core_en  output  1  core run enable.
REQ-012 core_dec  output  1  latched mode to core.
REQ-013 core_dout  input  8  cipher core result.
REQ-014 core_done  input  1  core result-valid pulse.
REQ-015 m_valid  output  1  result byte valid downstream.
REQ-016 m_data  output  8  result byte.
REQ-017 m_ready  input  1  downstream accepts m_data.
REQ-018 char_cnt  output  16  count of characters delivered downstream.
REQ-019 err  output  1  sticky core-timeout flag.

Function
REQ-020 s_ready SHALL equal "FIFO not full"; a byte transfers when s_valid && s_ready.
REQ-021 Transferred bytes 0x61-0x7A SHALL be pushed minus 0x20; 0x41-0x5A SHALL be pushed unchanged; all other bytes SHALL be accepted and discarded.
REQ-022 FSM states: IDLE, LOAD, WAIT, OUT.
REQ-023 IDLE: when FIFO non-empty, pop head into a holding register, latch mode_dec into core_dec, go to LOAD.
REQ-024 LOAD: exactly one cycle; core_valid=1, core_en=1, core_din=holding register; go to WAIT.
REQ-025 WAIT: core_en=1, core_valid=0, core_din held; on core_done=1 capture core_dout into m_data, go to OUT.
REQ-026 WAIT timeout counter SHALL clear on LOAD entry; if TIMEOUT cycles elapse in WAIT without core_done, set err=1, drop the character, go to IDLE.
REQ-027 OUT: m_valid=1, m_data stable; on m_ready=1 increment char_cnt (wrap 0xFFFF->0) and go to IDLE.
REQ-028 core_done outside WAIT SHALL be ignored.
REQ-029 core_en SHALL be 0 in IDLE and OUT.
REQ-030 Simultaneous FIFO push and pop in one cycle SHALL both take effect; occupancy unchanged.
REQ-031 Minimum per-character latency, FIFO write to m_valid: 3 cycles plus core latency.
REQ-032 mode_dec changes SHALL affect only characters popped after the change.
REQ-033 err SHALL remain 1 until reset; processing SHALL continue after a timeout.

Reset
REQ-034 On reset=1: FSM=IDLE, FIFO empty, s_ready=0 during reset cycle then 1, core_valid=0, core_en=0, core_din=0, core_dec=0, m_valid=0, m_data=0, char_cnt=0, err=0, timeout counter=0.
REQ-035 Reset in any state, including mid-WAIT or mid-OUT, SHALL discard the in-flight character without a downstream transfer.

Structure
REQ-036 Shared package enigma_pkg SHALL hold ASCII bounds (0x41, 0x5A, 0x61, 0x7A), case offset 0x20, and the FSM state enum.
REQ-037 The FIFO SHALL be a sub-module enigma_char_fifo (WIDTH 8, DEPTH FIFO_DEPTH, push/pop/full/empty).
REQ-038 Total RTL SHALL be 120-400 lines.

Verification
REQ-039 Send 'h' (0x68), mode_dec=0 -> core_din=0x48 with one-cycle core_valid, core_dec=0; model core returns 0x51 -> m_data=0x51, char_cnt=1.
REQ-040 Send '3', ' ', 'Z' -> only 0x5A reaches core; char_cnt=1 after drain.
REQ-041 Stall core (no core_done), m_ready=1, push 5 letters with FIFO_DEPTH=4 -> first pops to WAIT, next 4 fill FIFO, s_ready=0 until timeout.
REQ-042 core_done never asserted -> err=1 exactly TIMEOUT=64 cycles after LOAD, FSM back to IDLE, next character processed normally.
REQ-043 m_ready=0 for 10 cycles in OUT -> m_valid and m_data stable throughout, char_cnt unchanged until acceptance.
REQ-044 reset=1 during WAIT -> next cycle all outputs at reset values; late core_done ignored; no m_valid.
